// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word reads over a req/ack handshake,
// buffers returned words in a small prefetch queue and feeds one PC/IR
// pair per cycle to decode. Redirects flush the queue and drop any
// in-flight word.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  curr_state,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IR,
    output logic        IR_valid,
    output logic [31:0] fetch_cnt
);

    localparam int          PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW     = PW + 1;
    localparam logic [31:0] BUBBLE = 32'h0000_0020;
    localparam logic [1:0]  ST_RUN = 2'b01;

    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fpc_q, fpc_d;
    logic          discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic          valid_q, valid_d;
    logic [31:0]   cnt_q, cnt_d;

    logic [31:0]   qpc_q [DEPTH];
    logic [31:0]   qir_q [DEPTH];

    logic          ack_fire, enq, pop, pending_after, issue;
    logic [CW-1:0] count_next;

    // The low address bits of a redirect target are forced to zero.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake bookkeeping: a request acked on this edge no longer counts
    // as pending, which is what allows back-to-back single-cycle fetches.
    always_comb begin
        ack_fire      = req_q & imem_ack;
        enq           = ack_fire & ~discard_q & ~redirect;
        pop           = ~redirect & ~stall & (count_q != '0);
        count_next    = count_q + CW'(enq) - CW'(pop);
        pending_after = req_q & ~imem_ack;
        issue         = (curr_state == ST_RUN) & ~redirect & ~pending_after
                        & (count_next < CW'(DEPTH));
    end

    // Next-state for request, fetch pointer, queue pointers and output register.
    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        fpc_d     = fpc_q;
        discard_d = discard_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;

        // Request: launch a new one, hold the outstanding one, or go idle.
        if (issue) begin
            req_d  = 1'b1;
            addr_d = fpc_q;
        end else if (!pending_after) begin
            req_d  = 1'b0;
        end

        if (redirect) begin
            fpc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            fpc_d = fpc_q + 32'd4;
        end

        // A stale request still in flight must have its data thrown away.
        if (redirect && pending_after) begin
            discard_d = 1'b1;
        end else if (ack_fire) begin
            discard_d = 1'b0;
        end

        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ir_d    = BUBBLE;
            valid_d = 1'b0;
        end else begin
            count_d = count_next;
            if (enq) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (!stall) begin
                if (pop) begin
                    pc_d    = qpc_q[head_q];
                    ir_d    = qir_q[head_q];
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end else begin
                    ir_d    = BUBBLE;
                    valid_d = 1'b0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            fpc_q     <= RESET_PC;
            discard_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pc_q      <= RESET_PC;
            ir_q      <= BUBBLE;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            req_q     <= req_d;
            addr_q    <= addr_d;
            fpc_q     <= fpc_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    // Prefetch queue entries; each stores {address+4, word} when written.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] qpc_d, qir_d;

            // Load this entry only when it is the tail slot being filled.
            always_comb begin
                qpc_d = qpc_q[gi];
                qir_d = qir_q[gi];
                if (enq && (tail_q == PW'(gi))) begin
                    qpc_d = addr_q + 32'd4;
                    qir_d = imem_rdata;
                end
            end

            // Entry storage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    qpc_q[gi] <= '0;
                    qir_q[gi] <= '0;
                end else begin
                    qpc_q[gi] <= qpc_d;
                    qir_q[gi] <= qir_d;
                end
            end
        end
    endgenerate

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign IR_valid  = valid_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for streaming and
// stall behaviour, then hand-written sequences for async reset, redirect
// with a slow memory, redirect colliding with an ack, and IDLE draining.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  curr_state;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] PC;
    logic [31:0] IR;
    logic        IR_valid;
    logic [31:0] fetch_cnt;

    int tests  = 0;
    int failed = 0;
    int mem_lat = 1;
    int wcnt = 0;

    localparam logic [31:0] BUB = 32'h0000_0020;
    localparam logic [31:0] W0  = 32'h2001_0005;
    localparam logic [31:0] W1  = 32'h2002_0007;
    localparam logic [31:0] W2  = 32'h0022_1820;

    instruction_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .curr_state(curr_state), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PC(PC), .IR(IR), .IR_valid(IR_valid), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return W0;
            32'h4:   return W1;
            32'h8:   return W2;
            default: return 32'hC000_0000 | a;
        endcase
    endfunction

    // Memory model: acks mem_lat cycles after a request is presented.
    always @(negedge clk) begin
        if (!imem_req) begin
            wcnt     = 0;
            imem_ack = 1'b0;
        end else begin
            wcnt       = (imem_ack ? 0 : wcnt) + 1;
            imem_ack   = (wcnt >= mem_lat);
            imem_rdata = mem_word(imem_addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic show(input string tag);
        $display("[TB] %s req=%b addr=%h valid=%b ir=%h pc=%h cnt=%0d",
                 tag, imem_req, imem_addr, IR_valid, IR, PC, fetch_cnt);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // stream from reset, then a 4-cycle decode stall
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, BUB, 32'h00, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, BUB, 32'h00, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, W0,  32'h04, 32'd1};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, W1,  32'h08, 32'd2};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, W2,  32'h0C, 32'd3};
        tbl[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, W2,  32'h0C, 32'd3};
        tbl[6]  = '{1'b1, 1'b0, 32'h10, 1'b1, W2,  32'h0C, 32'd3};
        tbl[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, W2,  32'h0C, 32'd3};
        tbl[8]  = '{1'b1, 1'b0, 32'h10, 1'b1, W2,  32'h0C, 32'd3};
        tbl[9]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hC000_000C, 32'h10, 32'd4};
        tbl[10] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'hC000_0010, 32'h14, 32'd5};
        tbl[11] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'hC000_0014, 32'h18, 32'd6};

        rst = 1'b0; curr_state = 2'b01; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; mem_lat = 1;

        repeat (2) @(posedge clk);
        #1;
        show("reset");
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", PC, 32'h0);
        check("rst_ir", IR, BUB);
        check("rst_valid", {31'b0, IR_valid}, 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);
        #3 rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            stall = tbl[i].stall;
            edge_sample();
            show($sformatf("vec%0d", i));
            check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
            check($sformatf("vec%0d_valid", i), {31'b0, IR_valid}, {31'b0, tbl[i].valid});
            check($sformatf("vec%0d_ir", i), IR, tbl[i].ir);
            if (tbl[i].valid) check($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
            check($sformatf("vec%0d_cnt", i), fetch_cnt, tbl[i].cnt);
        end

        // Asynchronous reset between edges while a request is up.
        #1 rst = 1'b0;
        #1;
        show("async_rst");
        check("arst_req", {31'b0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_pc", PC, 32'h0);
        check("arst_ir", IR, BUB);
        check("arst_valid", {31'b0, IR_valid}, 32'd0);
        check("arst_cnt", fetch_cnt, 32'd0);
        #1 rst = 1'b1;

        edge_sample();
        show("restart");
        check("restart_addr", imem_addr, 32'h0);
        check("restart_req", {31'b0, imem_req}, 32'd1);
        repeat (3) @(posedge clk);
        edge_sample();
        show("pre_redirect");
        check("pre_rd_addr", imem_addr, 32'h10);
        check("pre_rd_ir", IR, W2);

        // Redirect to 0x41 while the 0x10 request waits on a 3-cycle memory.
        mem_lat = 3; redirect = 1'b1; redirect_pc = 32'h0000_0041;
        edge_sample();
        show("redirect");
        check("rd_valid", {31'b0, IR_valid}, 32'd0);
        check("rd_ir", IR, BUB);
        check("rd_hold_addr", imem_addr, 32'h10);
        redirect = 1'b0;
        edge_sample();
        show("rd_wait");
        check("rd_wait_req", {31'b0, imem_req}, 32'd1);
        check("rd_wait_valid", {31'b0, IR_valid}, 32'd0);
        edge_sample();
        show("rd_drop");
        check("rd_target_addr", imem_addr, 32'h40);
        check("rd_drop_valid", {31'b0, IR_valid}, 32'd0);
        mem_lat = 1;
        edge_sample();
        show("rd_nobypass");
        check("rd_nobypass_valid", {31'b0, IR_valid}, 32'd0);
        check("rd_next_addr", imem_addr, 32'h44);
        edge_sample();
        show("rd_first");
        check("rd_first_ir", IR, 32'hC000_0040);
        check("rd_first_pc", PC, 32'h44);
        check("rd_first_valid", {31'b0, IR_valid}, 32'd1);
        check("rd_first_cnt", fetch_cnt, 32'd4);

        // Redirect on the same edge as the ack for 0x48.
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        edge_sample();
        show("same_edge");
        check("se_req", {31'b0, imem_req}, 32'd0);
        check("se_valid", {31'b0, IR_valid}, 32'd0);
        redirect = 1'b0;
        edge_sample();
        show("se_issue");
        check("se_addr", imem_addr, 32'h100);
        check("se_req2", {31'b0, imem_req}, 32'd1);
        edge_sample();
        show("se_wait");
        check("se_empty_valid", {31'b0, IR_valid}, 32'd0);
        edge_sample();
        show("se_first");
        check("se_first_ir", IR, 32'hC000_0100);
        check("se_first_pc", PC, 32'h104);
        check("se_first_cnt", fetch_cnt, 32'd5);

        // Drop to IDLE mid-stream: pending ack lands, queue drains, bubbles follow.
        curr_state = 2'b00;
        edge_sample();
        show("idle0");
        check("idle0_req", {31'b0, imem_req}, 32'd0);
        check("idle0_ir", IR, 32'hC000_0104);
        check("idle0_pc", PC, 32'h108);
        edge_sample();
        show("idle1");
        check("idle1_ir", IR, 32'hC000_0108);
        check("idle1_pc", PC, 32'h10C);
        check("idle1_cnt", fetch_cnt, 32'd7);
        edge_sample();
        show("idle2");
        check("idle2_ir", IR, BUB);
        check("idle2_valid", {31'b0, IR_valid}, 32'd0);
        check("idle2_pc", PC, 32'h10C);
        edge_sample();
        show("idle3");
        check("idle3_req", {31'b0, imem_req}, 32'd0);
        check("idle3_cnt", fetch_cnt, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
